// File: rtl/csi2_raw10_unpacker.sv
// Purpose: follows frame/line sync from CSI-2 short packets and unpacks RAW10
//          long-packet payload into groups of four 10-bit pixels. All other data is dropped.
// Latency: every output is registered. A pixel group appears 1 cycle after the word that
//          completes it. frame_start/frame_end appear 1 cycle after the interrupt rising edge.
// Backpressure: none. The upstream receiver cannot be stalled, so input is consumed every cycle.
// Ports:   clock/reset (sync, active-high); virtual_channel, word_count, image_data,
//          image_data_type, image_data_enable, interrupt from the packet receiver;
//          pixel_data/pixel_valid plus line/frame markers, line_number and
//          length_error towards the image pipeline.
module csi2_raw10_unpacker #(
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
  parameter logic [5:0] RAW10_TYPE      = 6'h2B
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      virtual_channel,
  input  logic [15:0]     word_count,
  input  logic [3:0][7:0] image_data,
  input  logic [5:0]      image_data_type,
  input  logic            image_data_enable,
  input  logic            interrupt,
  output logic [3:0][9:0] pixel_data,
  output logic            pixel_valid,
  output logic            line_start,
  output logic            line_end,
  output logic            frame_start,
  output logic            frame_end,
  output logic [15:0]     line_number,
  output logic            length_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, LINE = 2'd1, DRAIN = 2'd2, SKIP = 2'd3} state_t;

  localparam logic [5:0] FS_TYPE = 6'h00;
  localparam logic [5:0] FE_TYPE = 6'h01;

  state_t          state_q, state_d;
  logic            irq_q, irq_d;
  logic            pending_q, pending_d;
  logic [15:0]     rem_q, rem_d;
  logic [7:0][7:0] buf_q, buf_d;
  logic [3:0]      level_q, level_d;
  logic            started_q, started_d;
  logic [3:0][9:0] pixel_data_q, pixel_data_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic            line_start_q, line_start_d;
  logic            line_end_q, line_end_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_end_q, frame_end_d;
  logic [15:0]     line_number_q, line_number_d;
  logic            length_error_q, length_error_d;

  logic            rise;
  logic            start;
  logic            vc_ok;
  logic            short_pkt;
  logic [2:0]      nbytes;
  logic [7:0][7:0] buf_app;
  logic [3:0]      level_app;
  logic [15:0]     rem_nxt;
  logic            emit;
  logic            done;
  logic [3:0][9:0] pixels;

  assign rise      = interrupt & ~irq_q;
  // A rising edge seen during DRAIN is held in pending_q and acted on in IDLE.
  assign start     = rise | pending_q;
  assign vc_ok     = (virtual_channel == VIRTUAL_CHANNEL);
  assign short_pkt = (image_data_type < 6'h10);

  // Byte buffer: append this cycle's valid bytes, then peel off one 5-byte group.
  always_comb begin
    nbytes = 3'd0;
    if (state_q == LINE && image_data_enable)
      nbytes = (rem_q > 16'd4) ? 3'd4 : rem_q[2:0];
    buf_app = buf_q;
    // The level is at most 4 before append, so level + i never passes byte 7.
    for (int i = 0; i < 4; i++)
      if (3'(i) < nbytes)
        buf_app[3'(level_q) + 3'(i)] = image_data[i];
    level_app = level_q + {1'b0, nbytes};
    emit      = (state_q == LINE) && (level_app >= 4'd5);
    rem_nxt   = rem_q - {13'd0, nbytes};
    for (int i = 0; i < 4; i++)
      pixels[i] = {buf_app[i], buf_app[4][2*i +: 2]};
    // The line ends when the byte count is exhausted or the packet ends early.
    done = (state_q == LINE) && ((rem_nxt == 16'd0) || !interrupt);
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!vc_ok)                            state_d = SKIP;
          else if (image_data_type == RAW10_TYPE) state_d = LINE;
          else if (!short_pkt)                   state_d = SKIP;
        end
      end
      LINE:    if (done) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      SKIP:    if (!interrupt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath updates
  always_comb begin
    irq_d          = interrupt;
    pending_d      = pending_q;
    rem_d          = rem_q;
    buf_d          = buf_q;
    level_d        = level_q;
    started_d      = started_q;
    line_number_d  = line_number_q;
    pixel_valid_d  = 1'b0;
    pixel_data_d   = '0;
    line_start_d   = 1'b0;
    line_end_d     = 1'b0;
    length_error_d = 1'b0;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        buf_d     = '0;
        level_d   = 4'd0;
        started_d = 1'b0;
        rem_d     = word_count;
        if (start && vc_ok) begin
          frame_start_d = (image_data_type == FS_TYPE);
          frame_end_d   = (image_data_type == FE_TYPE);
          if (image_data_type == FS_TYPE) line_number_d = 16'd0;
        end
      end
      LINE: begin
        rem_d          = rem_nxt;
        buf_d          = emit ? (buf_app >> 40) : buf_app;
        level_d        = emit ? (level_app - 4'd5) : level_app;
        started_d      = started_q | emit;
        pixel_valid_d  = emit;
        pixel_data_d   = emit ? pixels : '0;
        line_start_d   = emit & ~started_q;
        line_end_d     = done;
        // Residual bytes mean the count was not a multiple of 5. A non-zero remaining count means truncation.
        length_error_d = done & ((level_d != 4'd0) | (rem_nxt != 16'd0));
      end
      DRAIN: begin
        line_number_d = line_number_q + 16'd1;
        pending_d     = rise;
        buf_d         = '0;
        level_d       = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q          <= 1'b0;
      pending_q      <= 1'b0;
      rem_q          <= 16'd0;
      buf_q          <= '0;
      level_q        <= 4'd0;
      started_q      <= 1'b0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      line_start_q   <= 1'b0;
      line_end_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      line_number_q  <= 16'd0;
      length_error_q <= 1'b0;
    end else begin
      irq_q          <= irq_d;
      pending_q      <= pending_d;
      rem_q          <= rem_d;
      buf_q          <= buf_d;
      level_q        <= level_d;
      started_q      <= started_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      line_start_q   <= line_start_d;
      line_end_q     <= line_end_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      line_number_q  <= line_number_d;
      length_error_q <= length_error_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_valid  = pixel_valid_q;
  assign line_start   = line_start_q;
  assign line_end     = line_end_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign line_number  = line_number_q;
  assign length_error = length_error_q;

endmodule

// File: doc/csi2_raw10_unpacker.md
Name: csi2_raw10_unpacker

Overview:
- Sits directly downstream of the CSI-2 `camera` packet receiver and consumes its packet-layer outputs.
- Tracks frame and line sync from short packets.
- Unpacks RAW10 long-packet payload into 10-bit pixels, four per group.
- Forwards a pixel stream with line and frame markers to the image pipeline; all other data types are dropped.

Parameters:
- VIRTUAL_CHANNEL, 2'd0, only packets on this virtual channel are processed; all others are ignored.
- RAW10_TYPE, 6'h2B, data type of long packets to unpack.

Ports:
- clock  input  1  pixel-side clock, same domain as the camera outputs.
- reset  input  1  synchronous, active-high.
- virtual_channel  input  2  VC of the current packet from camera.
- word_count  input  16  byte count of the current long packet (short packets: data field).
- image_data  input  8x[3:0]  payload bytes; [0] is the earliest byte.
- image_data_type  input  6  data type of the current packet.
- image_data_enable  input  1  image_data holds a valid 4-byte word this cycle.
- interrupt  input  1  high for the duration of a packet presented by camera.
- pixel_data  output  10x[3:0]  four unpacked pixels; [0] is the leftmost.
- pixel_valid  output  1  pixel_data valid this cycle.
- line_start  output  1  pulse coincident with the first pixel_valid of a line.
- line_end  output  1  pulse coincident with the last pixel_valid of a line.
- frame_start  output  1  pulse on Frame Start short packet (type 0x00).
- frame_end  output  1  pulse on Frame End short packet (type 0x01).
- line_number  output  16  index of the current line within the frame; first line is 0.
- length_error  output  1  pulse when a RAW10 packet's word_count is not a multiple of 5.

Behaviour:
- Reset: all outputs 0, byte buffer empty, FSM in IDLE.
- Packet start: rising edge of interrupt, using a registered copy of the previous interrupt value.
  - If virtual_channel != VIRTUAL_CHANNEL, the FSM enters SKIP until interrupt falls.
- Short packets:
  - Type 0x00: frame_start pulses 1 cycle after the interrupt rising edge; line_number is cleared to 0.
  - Type 0x01: frame_end pulses 1 cycle after the interrupt rising edge.
  - Other short types are ignored.
- Long packets of any type other than RAW10_TYPE: SKIP.
- FSM states: IDLE -> (RAW10 rising edge) LINE -> DRAIN -> IDLE; IDLE -> SKIP -> IDLE on interrupt falling.
- LINE state:
  - bytes_remaining is loaded from word_count.
  - On each image_data_enable, valid = min(4, bytes_remaining) bytes are appended to an 8-byte buffer, and bytes_remaining is decremented by valid.
  - Buffer level stays within 0..8. Each cycle, if level ≥ 5 after append, the oldest 5 bytes B0..B4 are removed and emitted.
  - Pixel mapping: pixel_data[i] = {Bi, B4[2i+1:2i]}, for i = 0..3.
  - Latency: pixel_valid rises 1 cycle after the enabling input word.
  - line_start accompanies the first emit of the line.
- DRAIN state (entered when bytes_remaining reaches 0, or on interrupt falling):
  - line_end is asserted with the final emit; if there was no emit this line, line_end pulses alone.
  - line_number increments 1 cycle after line_end.
  - If residual level ≠ 0, length_error pulses with line_end and the residual bytes are discarded.
  - The buffer is cleared on entering IDLE.
- Bytes arriving after bytes_remaining reaches 0 (padding) are dropped.
- interrupt falling while in LINE with bytes_remaining > 0: treated as a truncated line; DRAIN and length_error.
- line_number wraps 0xFFFF -> 0.
- A new interrupt rising edge while in DRAIN is handled after DRAIN completes; DRAIN always lasts 1 cycle.
- Synchronous reset mid-line: buffer and FSM are cleared immediately; no line_end is produced.

Test Plan:
- Short packet type 0x00 with VC 0, then type 0x01 -> frame_start pulse, line_number 0, then frame_end pulse; no pixel_valid.
- RAW10 packet, word_count 5, bytes 12 34 56 78 E4 + 3 padding bytes -> one pixel_valid with pixels 0x048, 0x0D1, 0x15A, 0x1E3; line_start and line_end in the same cycle; line_number becomes 1.
- RAW10 packet, word_count 20, five back-to-back words -> pixel_valid on the 2nd-5th words, delayed 1 cycle each (4 groups, 16 pixels); line_start on the first, line_end on the last; no length_error.
- RAW10 packet, word_count 12 -> 2 groups emitted; length_error pulses with line_end; the next packet unpacks cleanly from an empty buffer.
- Packet with VC 1, and a packet of type 0x18 (YUV) on VC 0 -> no outputs of any kind; line_number unchanged.
- Reset asserted after 2 words of a 20-byte line -> all outputs 0 the next cycle; a subsequent 5-byte line produces the correct single group.
